// File: rtl/conv_window_feeder_pkg.sv
// Shared types and defaults for the 5x5 convolution window feeder.
package conv_pkg;
  localparam int K          = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;

  typedef logic [K-1:0][K-1:0][DEF_DATA_W-1:0] window_t;

  typedef enum logic [1:0] {FILL, ISSUE, WAIT, EMIT} feeder_state_t;
endpackage

// File: rtl/conv_window_feeder_if.sv
// Pixel input stream, conv unit bus and result output stream of the window feeder.
interface conv_window_feeder_if import conv_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
);
  logic                             pix_valid;
  logic                             pix_ready;
  logic [DATA_W-1:0]                pix_data;
  logic                             conv_start;
  logic [K-1:0][K-1:0][DATA_W-1:0]  conv_window;
  logic                             conv_done;
  logic [ACC_W-1:0]                 conv_result;
  logic                             out_valid;
  logic                             out_ready;
  logic [ACC_W-1:0]                 out_data;
  logic                             frame_done;

  modport master (
    input  pix_valid, pix_data, conv_done, conv_result, out_ready,
    output pix_ready, conv_start, conv_window, out_valid, out_data, frame_done
  );

  modport slave (
    output pix_valid, pix_data, conv_done, conv_result, out_ready,
    input  pix_ready, conv_start, conv_window, out_valid, out_data, frame_done
  );
endinterface

// File: rtl/conv_window_feeder_line_buffer.sv
// DEPTH-deep delay line advanced on en; storage is deliberately not cleared by reset.
module line_buffer #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = (ptr_q == PTR_W'(DEPTH-1)) ? '0 : ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Read-before-write at the same slot gives exactly DEPTH enables of delay.
  always_ff @(posedge clk) begin
    if (en) mem_q[ptr_q] <= din;
  end

  assign dout = mem_q[ptr_q];
endmodule

// File: rtl/conv_window_feeder.sv
// Builds 5x5 windows from a raster pixel stream, runs the conv unit per window, streams results.
//   state | meaning
//   FILL  | accept pixels, shift window and line buffers
//   ISSUE | one-cycle conv_start
//   WAIT  | window held, waiting for conv_done
//   EMIT  | result offered on out stream until out_ready
module conv_window_feeder import conv_pkg::*; #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input logic                  clk,
  input logic                  rst,
  conv_window_feeder_if.master bus
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W-1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H-1);

  feeder_state_t                   state_q, state_d;
  logic [COL_W-1:0]                col_q, col_d;
  logic [ROW_W-1:0]                row_q, row_d;
  logic [K-1:0][K-1:0][DATA_W-1:0] win_q, win_d;
  logic                            last_q, last_d;
  logic                            out_valid_q, out_valid_d;
  logic [ACC_W-1:0]                out_data_q, out_data_d;
  logic                            frame_done_q, frame_done_d;

  logic                            pix_ready;
  logic                            accept;
  logic [K-2:0][DATA_W-1:0]        lb_din, lb_dout;

  assign accept = bus.pix_valid && pix_ready;

  // Cascade: lb0 sees the new pixel, each later buffer is one more row older.
  always_comb begin
    lb_din[0] = bus.pix_data;
    for (int i = 1; i < K-1; i++) lb_din[i] = lb_dout[i-1];
  end

  for (genvar i = 0; i < K-1; i++) begin : g_lb
    line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .din  (lb_din[i]),
      .dout (lb_dout[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      last_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      last_q       <= last_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    last_d       = last_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K-1; c++) win_d[r][c] = win_q[r][c+1];
          // Row 0 is the oldest line, so it comes from the deepest buffer.
          for (int r = 0; r < K-1; r++) win_d[r][K-1] = lb_dout[K-2-r];
          win_d[K-1][K-1] = bus.pix_data;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (row_q >= ROW_W'(K-1) && col_q >= COL_W'(K-1)) begin
            state_d = ISSUE;
            last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.conv_done) begin
          out_data_d  = bus.conv_result;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = FILL;
          if (last_q) begin
            frame_done_d = 1'b1;
            row_d        = '0;
            col_d        = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    pix_ready       = (state_q == FILL);
    bus.pix_ready   = pix_ready;
    bus.conv_start  = (state_q == ISSUE);
    bus.conv_window = win_q;
    bus.out_valid   = out_valid_q;
    bus.out_data    = out_data_q;
    bus.frame_done  = frame_done_q;
  end
endmodule
